led_share_arbiter: RTL

Round-robin arbiter that shares the board's single status LED among four requesters. Each requester owns a distinct blink pattern. The arbiter grants the LED to one requester at a time, holds it for a minimum display time, and inserts a dark gap between owners so each pattern is visually distinct. It sits between the status sources and the LED pin, replacing a free-running blinker. One tick prescaler drives all timing.

---
 rtl/led_share_arbiter_if.sv | 10 +
 rtl/led_share_arbiter.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/led_share_arbiter_if.sv
// Request/grant/LED bundle between the status sources, the arbiter and the LED pin.
interface led_share_arbiter_if;
    logic [3:0] iREQ;
    logic [3:0] oGNT;
    logic       oLED;
    logic       oBUSY;

    modport master (output iREQ, input oGNT, oLED, oBUSY);
    modport slave  (input iREQ, output oGNT, oLED, oBUSY);
endinterface

// File: rtl/led_share_arbiter.sv
// Round-robin sharing of one status LED among four requesters, each with its own blink
// rate, a minimum hold time per owner and a dark gap between owners.
module led_share_arbiter #(
    parameter int unsigned TICK_DIV  = 500_000,
    parameter int unsigned BASE_HALF = 10,
    parameter int unsigned MIN_HOLD  = 50,
    parameter int unsigned GAP       = 20
) (
    input logic                iCLK,
    input logic                iRST,
    led_share_arbiter_if.slave bus
);
    localparam int unsigned PRESC_W = $clog2(TICK_DIV - 1) + 1;
    localparam int unsigned HOLD_W  = $clog2(MIN_HOLD) + 1;
    localparam int unsigned PHASE_W = $clog2(4 * BASE_HALF - 1) + 1;
    localparam int unsigned GAP_W   = $clog2(GAP) + 1;

    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
    localparam logic [HOLD_W-1:0]  HOLD_MAX   = HOLD_W'(MIN_HOLD);
    localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(MIN_HOLD - 1);
    localparam logic [GAP_W-1:0]   GAP_LAST   = GAP_W'(GAP - 1);

    typedef enum logic [1:0] {StIdle, StServe, StGap} state_e;

    state_e             stateQ, stateD;
    logic [PRESC_W-1:0] prescQ, prescD;
    logic [HOLD_W-1:0]  holdQ, holdD;
    logic [PHASE_W-1:0] phaseQ, phaseD;
    logic [GAP_W-1:0]   gapQ, gapD;
    logic [1:0]         ownerQ, ownerD;
    logic [1:0]         lastQ, lastD;
    logic [3:0]         gntQ, gntD;
    logic               ledQ, ledD;

    logic               tick;
    logic               holdDone;
    logic               othersReq;
    logic [1:0]         winner;
    logic [1:0]         idx;
    logic               found;
    logic [PHASE_W-1:0] phaseLim;

    assign tick      = (prescQ == PRESC_LAST);
    // Hold is satisfied either already, or by the tick landing this very cycle.
    assign holdDone  = (holdQ == HOLD_MAX) || (tick && (holdQ == HOLD_LAST));
    assign othersReq = |(bus.iREQ & ~(4'b0001 << ownerQ));

    // Search starts just after the previous owner, so the previous owner is tried last.
    always_comb begin
        winner = '0;
        idx    = '0;
        found  = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            idx = lastQ + 2'(i);
            if (!found && bus.iREQ[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        phaseLim = '0;
        unique case (ownerQ)
            2'd0: phaseLim = PHASE_W'(BASE_HALF - 1);
            2'd1: phaseLim = PHASE_W'(2 * BASE_HALF - 1);
            2'd2: phaseLim = PHASE_W'(3 * BASE_HALF - 1);
            2'd3: phaseLim = PHASE_W'(4 * BASE_HALF - 1);
            default: phaseLim = '0;
        endcase
    end

    always_comb begin
        stateD = stateQ;
        prescD = tick ? '0 : prescQ + PRESC_W'(1);
        holdD  = holdQ;
        phaseD = phaseQ;
        gapD   = gapQ;
        ownerD = ownerQ;
        lastD  = lastQ;
        gntD   = gntQ;
        ledD   = ledQ;

        unique case (stateQ)
            StIdle: begin
                if (|bus.iREQ) begin
                    stateD = StServe;
                    ownerD = winner;
                    lastD  = winner;
                    gntD   = 4'b0001 << winner;
                    ledD   = 1'b1;
                    holdD  = '0;
                    phaseD = '0;
                end
            end
            StServe: begin
                if (tick) begin
                    if (holdQ != HOLD_MAX) holdD = holdQ + HOLD_W'(1);
                    if (phaseQ == phaseLim) begin
                        phaseD = '0;
                        ledD   = ~ledQ;
                    end else begin
                        phaseD = phaseQ + PHASE_W'(1);
                    end
                end
                if (holdDone && (!bus.iREQ[ownerQ] || othersReq)) begin
                    stateD = StGap;
                    gntD   = '0;
                    ledD   = 1'b0;
                    gapD   = '0;
                end
            end
            StGap: begin
                if (tick) begin
                    if (gapQ == GAP_LAST) stateD = StIdle;
                    else gapD = gapQ + GAP_W'(1);
                end
            end
            default: stateD = StIdle;
        endcase

        // Every state starts with a full tick period.
        if (stateD != stateQ) prescD = '0;
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            stateQ <= StIdle;
            prescQ <= '0;
            holdQ  <= '0;
            phaseQ <= '0;
            gapQ   <= '0;
            ownerQ <= '0;
            lastQ  <= 2'd3;
            gntQ   <= '0;
            ledQ   <= 1'b0;
        end else begin
            stateQ <= stateD;
            prescQ <= prescD;
            holdQ  <= holdD;
            phaseQ <= phaseD;
            gapQ   <= gapD;
            ownerQ <= ownerD;
            lastQ  <= lastD;
            gntQ   <= gntD;
            ledQ   <= ledD;
        end
    end

    assign bus.oGNT  = gntQ;
    assign bus.oLED  = ledQ;
    assign bus.oBUSY = (stateQ != StIdle);
endmodule
